// File: rtl/axi_sram_sched_pkg.sv
// Shared definitions for the AXI-lite blocks: response codes and the
// scheduler FSM state encoding.
package axi_sram_sched_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MEM  = 3'd1,
    RD_RESP = 3'd2,
    WR_MEM  = 3'd3,
    WR_RESP = 3'd4
  } sram_state_t;

endpackage

// File: rtl/axi_sram_sched.sv
// AXI-lite to single-port SRAM scheduler. Reads and writes are serialised
// onto one SRAM port with a single transaction in flight; contention is
// resolved by alternating on the last granted direction.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   arvalid/arready/raddr               read address channel
//   rvalid/rready/rresp/rdata           read data channel
//   awvalid/awready/waddr               write address channel
//   wvalid/wready/strob/wdata           write data channel
//   bvalid/bready/bresp                 write response channel
//   mem_en/mem_we/mem_addr/mem_wdata    SRAM command (read data one cycle
//   mem_rdata                           after a mem_en with mem_we==0)
module axi_sram_sched
  import axi_sram_sched_pkg::*;
#(
  parameter int                  DATA_LEN  = 32,
  parameter int                  ADDR_LEN  = 32,
  parameter int                  STROB_LEN = 4,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  SIZE_LOG2 = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_LEN-1:0]  raddr,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [2:0]           rresp,
  output logic [DATA_LEN-1:0]  rdata,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_LEN-1:0]  waddr,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [STROB_LEN-1:0] strob,
  input  logic [DATA_LEN-1:0]  wdata,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [2:0]           bresp,
  output logic                 mem_en,
  output logic [STROB_LEN-1:0] mem_we,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  input  logic [DATA_LEN-1:0]  mem_rdata
);

  sram_state_t          state, state_n;
  logic                 last_wr;
  logic                 hit_q;
  logic                 rd_fresh;
  logic [ADDR_LEN-1:0]  addr_q;
  logic [DATA_LEN-1:0]  wdata_q;
  logic [STROB_LEN-1:0] strob_q;
  logic [DATA_LEN-1:0]  rdata_q;

  logic rd_req, wr_req, rd_win, wr_win;
  logic rd_hs, wr_hs;

  // Unsigned, ADDR_LEN-wide window test; a window at least as wide as the
  // address space decodes everything.
  function automatic logic addr_hit(input logic [ADDR_LEN-1:0] a);
    logic [ADDR_LEN-1:0] off;
    off = a - BASE_ADDR;
    if (SIZE_LOG2 >= ADDR_LEN) return 1'b1;
    return (off >> SIZE_LOG2) == '0;
  endfunction

  assign rd_req = arvalid;
  assign wr_req = awvalid && wvalid;
  assign rd_win = rd_req && (!wr_req || last_wr);
  assign wr_win = wr_req && (!rd_req || !last_wr);
  assign rd_hs  = arready && arvalid;
  assign wr_hs  = awready && wready && wr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_wr  <= 1'b1;
      hit_q    <= 1'b0;
      rd_fresh <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strob_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      rd_fresh <= (state == RD_MEM);
      if (rd_hs) begin
        addr_q  <= raddr;
        hit_q   <= addr_hit(raddr);
        last_wr <= 1'b0;
      end else if (wr_hs) begin
        addr_q  <= waddr;
        wdata_q <= wdata;
        strob_q <= strob;
        hit_q   <= addr_hit(waddr);
        last_wr <= 1'b1;
      end
      if (state == RD_RESP && rd_fresh)
        rdata_q <= hit_q ? mem_rdata : '0;
    end
  end

  always_comb begin
    state_n   = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    rresp     = RESP_OKAY;
    rdata     = rdata_q;
    bvalid    = 1'b0;
    bresp     = RESP_OKAY;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (rd_win) begin
            arready = 1'b1;
            state_n = RD_MEM;
          end else if (wr_win) begin
            awready = 1'b1;
            wready  = 1'b1;
            state_n = WR_MEM;
          end
        end
      end
      RD_MEM: begin
        if (hit_q) begin
          mem_en   = 1'b1;
          mem_addr = addr_q;
        end
        state_n = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        rresp  = hit_q ? RESP_OKAY : RESP_SLVERR;
        // SRAM data only becomes valid in the first response cycle, so that
        // cycle forwards it directly and later cycles show the captured copy.
        if (rd_fresh) rdata = hit_q ? mem_rdata : '0;
        if (rready) state_n = IDLE;
      end
      WR_MEM: begin
        if (hit_q) begin
          mem_en    = 1'b1;
          mem_we    = strob_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        state_n = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = hit_q ? RESP_OKAY : RESP_SLVERR;
        if (bready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_sched.sv
module tb_axi_sram_sched;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] raddr, rdata;
  logic [2:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] waddr, wdata;
  logic [3:0]  strob;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_sram_sched #(
    .DATA_LEN (32),
    .ADDR_LEN (32),
    .STROB_LEN(4),
    .BASE_ADDR(BASE),
    .SIZE_LOG2(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .raddr(raddr),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .waddr(waddr),
    .wvalid(wvalid), .wready(wready), .strob(strob), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM behaviour: registered read, byte-enabled write.
  logic [31:0] sram [int unsigned];
  initial mem_rdata = '0;
  always @(posedge clk) begin : sram_model
    int unsigned k;
    if (mem_en) begin
      k = mem_addr >> 2;
      if (mem_we == 4'b0000) begin
        mem_rdata <= sram.exists(k) ? sram[k] : 32'h0;
      end else begin
        if (!sram.exists(k)) sram[k] = 32'h0;
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[k][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model of memory contents as seen through the AXI side.
  logic [31:0] ref_mem [int unsigned];

  function automatic bit ref_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'h0001_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int unsigned k;
    logic [31:0] cur;
    k = a >> 2;
    cur = ref_read(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[k] = cur;
  endtask

  task automatic check(input string tag, input string what,
                       input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, what, got, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  strob;
    logic [31:0] wdata;
    bit          hit;
    logic [2:0]  resp;
    logic [31:0] rdata;
    int          hold;
  } vec_t;

  task automatic do_txn(input vec_t v, input string tag);
    bit got;
    @(posedge clk); #1;
    if (v.is_wr) begin
      awvalid = 1'b1; wvalid = 1'b1; waddr = v.addr; strob = v.strob; wdata = v.wdata;
    end else begin
      arvalid = 1'b1; raddr = v.addr;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = v.is_wr ? (awready && wready) : arready;
    end
    check(tag, "grant", 64'(got), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (!got) return;
    @(negedge clk);
    check(tag, "mem_en", 64'(mem_en), 64'(v.hit));
    check(tag, "mem_we", 64'(mem_we), (v.is_wr && v.hit) ? 64'(v.strob) : 64'(0));
    if (v.hit) check(tag, "mem_addr", 64'(mem_addr), 64'(v.addr));
    if (v.hit && v.is_wr) check(tag, "mem_wdata", 64'(mem_wdata), 64'(v.wdata));
    check(tag, "early_valid", 64'({rvalid, bvalid}), 64'(0));
    @(negedge clk);
    if (v.hit && v.is_wr) ref_write(v.addr, v.strob, v.wdata);
    if (v.hold > 0) begin
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    end
    for (int h = 0; h <= v.hold; h++) begin
      if (h > 0) @(negedge clk);
      if (v.is_wr) begin
        check(tag, "bvalid", 64'(bvalid), 64'(1));
        check(tag, "bresp", 64'(bresp), 64'(v.resp));
      end else begin
        check(tag, "rvalid", 64'(rvalid), 64'(1));
        check(tag, "rresp", 64'(rresp), 64'(v.resp));
        check(tag, "rdata", 64'(rdata), 64'(v.rdata));
      end
      if (h > 0) check(tag, "busy_ready", 64'({arready, awready, wready}), 64'(0));
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    check(tag, "resp_done", 64'({rvalid, bvalid}), 64'(0));
    rready = 1'b0; bready = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[$];
  vec_t v;
  bit   exp_lw, w;
  int   ngr, last_c;

  initial begin
    rst_n = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b0; bready = 1'b0;
    raddr = BASE; waddr = BASE; strob = '0; wdata = '0;
    sram[(BASE + 32'h4) >> 2] = 32'hDEAD_BEEF;
    ref_mem[(BASE + 32'h4) >> 2] = 32'hDEAD_BEEF;

    // Reset state with requests pending
    repeat (3) @(negedge clk);
    check("reset", "readies", 64'({arready, awready, wready}), 64'(0));
    check("reset", "valids", 64'({rvalid, bvalid}), 64'(0));
    check("reset", "mem", 64'({mem_en, mem_we}), 64'(0));
    check("reset", "mem_addr", 64'(mem_addr), 64'(0));
    check("reset", "rdata", 64'(rdata), 64'(0));
    check("reset", "resps", 64'({rresp, bresp}), 64'(0));
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b1;

    // Contention from reset: read first, then alternate, 3 cycles apart
    @(posedge clk); #1;
    rready = 1'b1; bready = 1'b1;
    arvalid = 1'b1; raddr = BASE + 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; waddr = BASE + 32'h40; strob = 4'b0000; wdata = '0;
    exp_lw = 1'b1; ngr = 0; last_c = 0;
    for (int c = 0; c < 40 && ngr < 3; c++) begin
      @(negedge clk);
      if (arready || (awready && wready)) begin
        w = !exp_lw;
        check("contend", "grant", 64'({arready, awready && wready}), w ? 64'(1) : 64'(2));
        if (ngr > 0) check("contend", "spacing", 64'(c - last_c), 64'(3));
        last_c = c; exp_lw = w; ngr++;
      end
    end
    check("contend", "grants", 64'(ngr), 64'(3));
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (4) @(negedge clk);
    rready = 1'b0; bready = 1'b0;

    // Directed table
    tbl.push_back('{0, BASE + 32'h4,      4'h0, 32'h0,         1, 3'b000, 32'hDEAD_BEEF, 0});
    tbl.push_back('{1, BASE + 32'h8,      4'h3, 32'h1234_5678, 1, 3'b000, 32'h0,         0});
    tbl.push_back('{0, BASE + 32'h8,      4'h0, 32'h0,         1, 3'b000, 32'h0000_5678, 5});
    tbl.push_back('{0, BASE + 32'h1_0000, 4'h0, 32'h0,         0, 3'b010, 32'h0,         0});
    tbl.push_back('{1, BASE - 32'h4,      4'hF, 32'hCAFE_F00D, 0, 3'b010, 32'h0,         2});
    tbl.push_back('{1, BASE + 32'h8,      4'h0, 32'hFFFF_FFFF, 1, 3'b000, 32'h0,         0});
    tbl.push_back('{1, BASE + 32'hC,      4'hC, 32'hA5A5_0000, 1, 3'b000, 32'h0,         1});
    tbl.push_back('{0, BASE + 32'h8,      4'h0, 32'h0,         1, 3'b000, 32'h0000_5678, 0});
    tbl.push_back('{0, BASE + 32'hC,      4'h0, 32'h0,         1, 3'b000, 32'hA5A5_0000, 0});
    tbl.push_back('{0, BASE + 32'hFFFC,   4'h0, 32'h0,         1, 3'b000, 32'h0,         0});
    tbl.push_back('{0, 32'h0,             4'h0, 32'h0,         0, 3'b010, 32'h0,         0});
    tbl.push_back('{0, BASE - 32'h4,      4'h0, 32'h0,         0, 3'b010, 32'h0,         0});
    foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      v.is_wr = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 4))
        0:       v.addr = BASE + 32'h1_0000 + ($urandom_range(0, 15) << 2);
        1:       v.addr = BASE - 32'h4 - ($urandom_range(0, 15) << 2);
        2:       v.addr = BASE + 32'hFFC0 + ($urandom_range(0, 15) << 2);
        default: v.addr = BASE + ($urandom_range(0, 15) << 2);
      endcase
      v.strob = 4'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.hit   = ref_hit(v.addr);
      v.resp  = v.hit ? 3'b000 : 3'b010;
      v.rdata = v.hit ? ref_read(v.addr) : 32'h0;
      v.hold  = $urandom_range(0, 3);
      do_txn(v, $sformatf("rnd%0d", n));
    end

    // Reset while a write is in its SRAM cycle
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; waddr = BASE + 32'h800; strob = 4'hF; wdata = 32'hAAAA_5555;
    @(negedge clk);
    check("rstwr", "grant", 64'(awready && wready), 64'(1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("rstwr", "pre_we", 64'(mem_we), 64'(4'hF));
    #1 rst_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check("rstwr", "mem_we", 64'(mem_we), 64'(0));
    check("rstwr", "mem_en", 64'(mem_en), 64'(0));
    check("rstwr", "awready", 64'({awready, wready}), 64'(0));
    repeat (2) @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstwr", "idle", 64'({rvalid, bvalid, mem_en}), 64'(0));
    v = '{0, BASE + 32'h800, 4'h0, 32'h0, 1, 3'b000, 32'h0, 0};
    do_txn(v, "rstwr_rd");
    v = '{1, BASE + 32'h800, 4'hF, 32'h0BAD_CAFE, 1, 3'b000, 32'h0, 0};
    do_txn(v, "rstwr_wr");
    v = '{0, BASE + 32'h800, 4'h0, 32'h0, 1, 3'b000, 32'h0BAD_CAFE, 1};
    do_txn(v, "rstwr_rd2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_sched.md
AXI_SRAM_SCHED -- requirements
Module: axi_sram_sched

Interface
REQ-001 SHALL take parameter DATA_LEN, default 32, meaning the data width.
REQ-002 SHALL take parameter ADDR_LEN, default 32, meaning the address width.
REQ-003 SHALL take parameter STROB_LEN, default 4, meaning the byte-strobe width (DATA_LEN/8).
REQ-004 SHALL take parameter BASE_ADDR, default 32'h8000_0000, meaning the first decoded address.
REQ-005 SHALL take parameter SIZE_LOG2, default 16, meaning the log2 of the decoded window size in bytes.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-007 clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 arvalid  in  1 / arready  out  1 / raddr  in  ADDR_LEN  read address channel.
REQ-009 rvalid  out  1 / rready  in  1 / rresp  out  3 / rdata  out  DATA_LEN  read data channel.
REQ-010 awvalid  in  1 / awready  out  1 / waddr  in  ADDR_LEN  write address channel.
REQ-011 wvalid  in  1 / wready  out  1 / strob  in  STROB_LEN / wdata  in  DATA_LEN  write data channel.
REQ-012 bvalid  out  1 / bready  in  1 / bresp  out  3  write response channel.
REQ-013 mem_en  out  1 / mem_we  out  STROB_LEN / mem_addr  out  ADDR_LEN / mem_wdata  out  DATA_LEN / mem_rdata  in  DATA_LEN  single-port SRAM; read data is valid one cycle after mem_en with mem_we==0.

Function
REQ-014 SHALL serialise AXI-lite reads and writes onto the single SRAM port, with one transaction in flight.
REQ-015 FSM states SHALL be IDLE, RD_MEM, RD_RESP, WR_MEM and WR_RESP.
REQ-016 Write request = awvalid && wvalid; a lone awvalid or a lone wvalid SHALL NOT be accepted.
REQ-017 In IDLE, a lone request wins; when both are pending, read wins if last_wr==1, else write.
REQ-018 arready SHALL be 1 only in IDLE while the read wins; awready and wready SHALL both be 1 only in IDLE while the write wins.
REQ-019 On a handshake SHALL latch the address (and wdata/strob for writes), set last_wr (1 for write, 0 for read), and go to RD_MEM or WR_MEM.
REQ-020 Address hit = (addr - BASE_ADDR) < 2**SIZE_LOG2, computed unsigned and ADDR_LEN wide.
REQ-021 RD_MEM on hit: mem_en=1, mem_we=0, mem_addr=latched address; on miss: mem_en=0. Always go to RD_RESP next.
REQ-022 RD_RESP SHALL hold rvalid=1 with rdata registered from mem_rdata on entry (0 on miss) and rresp 3'b000 on hit / 3'b010 on miss, stable until rready; the rready cycle returns to IDLE.
REQ-023 WR_MEM on hit: mem_en=1, mem_we=strob, mem_wdata=wdata; on miss: mem_en=0, mem_we=0. Always go to WR_RESP next.
REQ-024 WR_RESP SHALL hold bvalid=1 with bresp 3'b000 / 3'b010 until bready; the bready cycle returns to IDLE.
REQ-025 Latency: handshake at cycle T gives mem_en at T+1 and rvalid/bvalid at T+2. Minimum spacing between handshakes is 3 cycles; there is no bypass from a response state to a new request.
REQ-026 A strob of 0 on a hit SHALL still produce mem_en=1 with mem_we=0; the rdata result is discarded and bresp is OKAY.
REQ-027 mem_en, mem_we, rvalid and bvalid SHALL be 0 in every state not named above.

Reset
REQ-028 Asserting rst_n low at any time SHALL force IDLE and last_wr=1, clear rvalid, bvalid, rresp, bresp, rdata and mem_* outputs to 0, and abandon any in-flight transaction without issuing an SRAM write.
REQ-029 arready, awready and wready SHALL be 0 while rst_n is low.

Structure
REQ-030 The resp codes (OKAY 3'b000, SLVERR 3'b010) and the FSM state encoding SHALL live in a shared package used by all AXI blocks.
REQ-031 SHALL be a single module with no sub-module; the request picker is inline.

Verification
REQ-032 Read hit: arvalid with raddr=BASE_ADDR+4 and mem_rdata=32'hDEADBEEF -> mem_en at T+1 with mem_addr=BASE+4, then rvalid at T+2 with rdata=DEADBEEF and rresp=0.
REQ-033 Write hit: aw/w valid with waddr=BASE+8, strob=4'b0011 and wdata=32'h1234_5678 -> mem_we=4'b0011 at T+1, then bvalid at T+2 with bresp=0.
REQ-034 Contention: read and write both pending from reset -> read granted first, then write, then read again (alternating).
REQ-035 Miss: raddr=BASE+2**SIZE_LOG2 -> mem_en stays 0, rresp=3'b010, rdata=0.
REQ-036 Backpressure: rready held 0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout.
REQ-037 Reset during WR_MEM -> mem_we=0 immediately and IDLE after release; the next transaction completes normally.
